mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory-access stage of the 5-stage core, between the EX/MEM pipeline register and the register file's write port.
- Takes one instruction at a time from EX. Issues word loads and stores to the data memory over a valid/ready request channel with a separate response channel.
- Produces the registered MEM/WB write-back fields (opcode, rd, value) that the register file consumes.
- Stalls upstream with in_ready while a memory access is outstanding.

Parameters:
- ADDR_W, 32, data memory address width
- DATA_W, 32, data word width; must equal register width

Ports:
- clock  in  1  core clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  EX/MEM holds a valid instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_opcode  in  7  RV32 major opcode
- in_rd  in  5  destination register
- in_alu_result  in  DATA_W  ALU result; effective address for LW/SW
- in_store_data  in  DATA_W  rs2 value for SW
- dmem_req_valid  out  1  memory request valid
- dmem_req_ready  in  1  memory accepts the request
- dmem_req_we  out  1  1 = store, 0 = load
- dmem_req_addr  out  ADDR_W  word-aligned byte address
- dmem_req_wdata  out  DATA_W  store data
- dmem_resp_valid  in  1  load data valid, single-cycle pulse
- dmem_resp_rdata  in  DATA_W  load data
- wb_valid  out  1  write-back fields valid this cycle
- wb_opcode  out  7  opcode to the register file
- wb_rd  out  5  destination register
- wb_value  out  DATA_W  write-back value

Behaviour:
- Interface decisions: one clock, `clock`. Reset `reset` is synchronous and active-high.
- Reset: state returns to IDLE. All registered outputs are 0: wb_*, dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata.
- Opcodes: LW=0000011, SW=0100011, ALUopR=0110011, ALUopI=0010011. Any other opcode passes through as non-writing.
- The register file writes on opcode alone. Therefore whenever wb_valid=0, wb_opcode=0, wb_rd=0 and wb_value=0. wb_valid is a one-cycle pulse per retired instruction.
- FSM states: IDLE, REQ, RESP.
- in_ready = (state==IDLE). It is combinational from state only.
- IDLE, in_valid=1, non-memory opcode:
  - Next cycle: wb_valid=1, wb_opcode=in_opcode, wb_rd=in_rd, wb_value=in_alu_result.
  - State stays IDLE. Latency 1; throughput 1 per cycle.
- IDLE, in_valid=1, LW/SW:
  - Latch rd, address and store data. Go to REQ. No wb pulse.
- REQ:
  - dmem_req_valid=1. we/addr/wdata are held stable until dmem_req_ready=1.
  - On handshake, dmem_req_valid drops the next cycle.
  - SW: next cycle wb_valid=1, wb_opcode=SW, wb_rd=0, wb_value=0. Go to IDLE.
  - LW: go to RESP.
- RESP:
  - On dmem_resp_valid, next cycle wb_valid=1, wb_opcode=LW, wb_rd=latched rd, wb_value=dmem_resp_rdata. Go to IDLE.
- Minimum LW latency:
  - Accept at T, handshake at T+1, response at T+2 at the earliest, wb at T+3.
  - The next instruction is accepted at T+3.
- Boundary conditions:
  - dmem_resp_valid is ignored outside RESP, including a stale response arriving after a reset.
  - LW with rd=0 performs the memory read, then emits wb_rd=0; the register file discards it.
  - in_valid while not IDLE: not accepted; upstream holds the instruction.
  - Reset in REQ or RESP abandons the access. dmem_req_valid is 0 the cycle after reset is asserted. No wb pulse is produced.
- Address: without the optional feature, dmem_req_addr = {in_alu_result[ADDR_W-1:2], 2'b00}.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - Adds output port misalign_err (1 bit).
  - An LW/SW with in_alu_result[1:0]!=0 issues no memory request and stays in IDLE.
  - Next cycle misalign_err=1 for one cycle, with wb_valid=1, wb_opcode=0, wb_rd=0. The instruction is dropped.
- Undefined:
  - No port. The low address bits are silently cleared and the access proceeds normally.

Decomposition:
- Shared package: opcode constants (LW, SW, ALUopR, ALUopI) and the state enum typedef (IDLE/REQ/RESP).
- Shared package: mem_wb field typedef (valid, opcode, rd, value), so the register file side can switch to the packed bus.
- No sub-module; FSM plus output register in a single module.

Test Plan:
- ALUopR rd=5 result=0x1234 in cycle T -> wb_valid at T+1, wb_opcode=0110011, wb_rd=5, wb_value=0x1234; in_ready stays 1.
- LW addr=0x40 rd=7, mem ready immediately, resp_rdata=0xDEADBEEF one cycle later -> req_addr=0x40, we=0; wb at T+3 with rd=7, value=0xDEADBEEF; in_ready=0 for T+1..T+2.
- SW addr=0x80 data=0xCAFE, dmem_req_ready held low 3 cycles -> addr/wdata/we=1 stable through all 4 request cycles; single wb pulse with opcode SW, rd=0.
- Idle with no instruction, then stray dmem_resp_valid=1 -> wb_valid stays 0 and wb_opcode=0 throughout.
- Reset asserted while in RESP, response arrives the next cycle -> no wb pulse; dmem_req_valid=0; in_ready=1 after reset.
- With MEM_MISALIGN_TRAP_EN, LW addr=0x42 -> no dmem_req_valid; misalign_err pulse at T+1. Without the macro -> request issued with addr=0x40.

Source files
------------

// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_pkg
// Description : Shared opcodes, FSM state type and MEM/WB bundle for mem_stage.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_ALUR = 7'b0110011;
    localparam logic [6:0] OP_ALUI = 7'b0010011;

    localparam int WB_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Packed MEM/WB bundle for register-file consumers that prefer a single bus
    typedef struct packed {
        logic                 valid;
        logic [6:0]           opcode;
        logic [4:0]           rd;
        logic [WB_DATA_W-1:0] value;
    } mem_wb_t;

    function automatic logic is_mem_op(input logic [6:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : Memory-access pipeline stage; issues word loads/stores to data
//               memory and registers the MEM/WB write-back fields.
//               Optional macro MEM_MISALIGN_TRAP_EN adds misalign_err and drops
//               misaligned LW/SW instead of clearing the low address bits.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_store_data,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic              dmem_req_we,
    output logic [ADDR_W-1:0] dmem_req_addr,
    output logic [DATA_W-1:0] dmem_req_wdata,
    input  logic              dmem_resp_valid,
    input  logic [DATA_W-1:0] dmem_resp_rdata,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic              misalign_err,
`endif
    output logic              wb_valid,
    output logic [6:0]        wb_opcode,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_value
);

    state_t              state_q, state_d;
    logic                is_load_q, is_load_d;
    logic [4:0]          rd_q, rd_d;
    logic                req_valid_q, req_valid_d;
    logic                req_we_q, req_we_d;
    logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
    logic [DATA_W-1:0]   req_wdata_q, req_wdata_d;
    logic                wb_valid_q, wb_valid_d;
    logic [6:0]          wb_opcode_q, wb_opcode_d;
    logic [4:0]          wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0]   wb_value_q, wb_value_d;
    logic                w_is_mem;
    logic                w_misaligned;

`ifdef MEM_MISALIGN_TRAP_EN
    logic                misalign_q, misalign_d;
    assign w_misaligned = (in_alu_result[1:0] != 2'b00);
`else
    assign w_misaligned = 1'b0;
`endif

    assign w_is_mem = is_mem_op(in_opcode);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && w_is_mem && !w_misaligned) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (dmem_req_ready) begin
                    state_d = is_load_q ? ST_RESP : ST_IDLE;
                end
            end
            ST_RESP: begin
                if (dmem_resp_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath next values
    // ------------------------------------------------------------------
    assign in_ready = (state_q == ST_IDLE);

    always_comb begin
        is_load_d   = is_load_q;
        rd_d        = rd_q;
        req_we_d    = req_we_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        // Request valid tracks REQ exactly, so it falls the cycle after the handshake
        req_valid_d = (state_d == ST_REQ);
        wb_valid_d  = 1'b0;
        wb_opcode_d = 7'd0;
        wb_rd_d     = 5'd0;
        wb_value_d  = '0;
`ifdef MEM_MISALIGN_TRAP_EN
        misalign_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (!w_is_mem) begin
                        wb_valid_d  = 1'b1;
                        wb_opcode_d = in_opcode;
                        wb_rd_d     = in_rd;
                        wb_value_d  = in_alu_result;
                    end else if (w_misaligned) begin
`ifdef MEM_MISALIGN_TRAP_EN
                        wb_valid_d  = 1'b1;
                        misalign_d  = 1'b1;
`endif
                    end else begin
                        is_load_d   = (in_opcode == OP_LW);
                        rd_d        = in_rd;
                        req_we_d    = (in_opcode == OP_SW);
                        req_addr_d  = {in_alu_result[ADDR_W-1:2], 2'b00};
                        req_wdata_d = in_store_data;
                    end
                end
            end
            ST_REQ: begin
                if (dmem_req_ready && !is_load_q) begin
                    wb_valid_d  = 1'b1;
                    wb_opcode_d = OP_SW;
                end
            end
            ST_RESP: begin
                if (dmem_resp_valid) begin
                    wb_valid_d  = 1'b1;
                    wb_opcode_d = OP_LW;
                    wb_rd_d     = rd_q;
                    wb_value_d  = dmem_resp_rdata;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and MEM/WB output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            is_load_q   <= 1'b0;
            rd_q        <= 5'd0;
            req_valid_q <= 1'b0;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            wb_valid_q  <= 1'b0;
            wb_opcode_q <= 7'd0;
            wb_rd_q     <= 5'd0;
            wb_value_q  <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            is_load_q   <= is_load_d;
            rd_q        <= rd_d;
            req_valid_q <= req_valid_d;
            req_we_q    <= req_we_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            wb_valid_q  <= wb_valid_d;
            wb_opcode_q <= wb_opcode_d;
            wb_rd_q     <= wb_rd_d;
            wb_value_q  <= wb_value_d;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_q  <= misalign_d;
`endif
        end
    end

    assign dmem_req_valid = req_valid_q;
    assign dmem_req_we    = req_we_q;
    assign dmem_req_addr  = req_addr_q;
    assign dmem_req_wdata = req_wdata_q;
    assign wb_valid       = wb_valid_q;
    assign wb_opcode      = wb_opcode_q;
    assign wb_rd          = wb_rd_q;
    assign wb_value       = wb_value_q;
`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign_err   = misalign_q;
`endif

endmodule
`default_nettype wire
